// File: rtl/sram256x8_req_ctrl_if.sv
// Request/response bus between a requester and the SRAM front end.
// The master drives requests and response backpressure; the slave is the controller.
interface sram256x8_req_ctrl_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_WE;
  logic [7:0] REQ_ADDR;
  logic [7:0] REQ_WDATA;
  logic [7:0] REQ_WMASK;
  logic       RSP_VALID;
  logic       RSP_READY;
  logic [7:0] RSP_RDATA;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_WMASK, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_WMASK, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RDATA
  );
endinterface

// File: rtl/sram256x8_req_ctrl.sv
// Front end for the 256x8 bit-maskable single-port SRAM macro.
// Turns a valid/ready request stream into macro cycles, holds read data in a
// backpressured response register, and fills the array with INIT_VALUE after
// reset or on a CLEAR pulse.
module sram256x8_req_ctrl #(
  parameter bit         INIT_ON_RESET = 1'b1,
  parameter logic [7:0] INIT_VALUE    = 8'h00
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CLEAR,
  output logic                        INIT_DONE,
  sram256x8_req_ctrl_if.slave         bus,
  output logic                        SRAM_CEN,
  output logic                        SRAM_GWEN,
  output logic [7:0]                  SRAM_WEN,
  output logic [7:0]                  SRAM_A,
  output logic [7:0]                  SRAM_D,
  input  logic [7:0]                  SRAM_Q
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       rd_pend;
  logic       clear_pending;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       req_ready;
  logic       acc;

  // One read in flight at a time; a held response only blocks if it is not
  // being drained this cycle. Forced low during reset so the first cycle is clean.
  assign req_ready = ~RST & (state == S_RUN) & ~rd_pend & ~clear_pending &
                     (~rsp_valid | bus.RSP_READY);
  assign acc       = bus.REQ_VALID & req_ready;

  assign bus.REQ_READY = req_ready;
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_RDATA = rsp_rdata;
  assign INIT_DONE     = (state == S_RUN);

  // Macro pins: the macro samples these at the next edge, so they are a pure
  // function of current state and the request accepted this cycle.
  always_comb begin
    SRAM_CEN  = 1'b1;
    SRAM_GWEN = 1'b1;
    SRAM_WEN  = 8'hFF;
    SRAM_A    = 8'h00;
    SRAM_D    = 8'h00;
    if (!RST) begin
      if (state == S_INIT) begin
        SRAM_CEN  = 1'b0;
        SRAM_GWEN = 1'b0;
        SRAM_WEN  = 8'h00;
        SRAM_A    = cnt;
        SRAM_D    = INIT_VALUE;
      end else if (acc) begin
        if (bus.REQ_WE) begin
          // An all-zero mask is accepted but never touches the macro.
          if (|bus.REQ_WMASK) begin
            SRAM_CEN  = 1'b0;
            SRAM_GWEN = 1'b0;
            SRAM_WEN  = ~bus.REQ_WMASK;
            SRAM_A    = bus.REQ_ADDR;
            SRAM_D    = bus.REQ_WDATA;
          end
        end else begin
          SRAM_CEN = 1'b0;
          SRAM_A   = bus.REQ_ADDR;
        end
      end
    end
  end

  // Control FSM, fill counter, read tracking and the response register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= INIT_ON_RESET ? S_INIT : S_RUN;
      cnt           <= 8'h00;
      rd_pend       <= 1'b0;
      clear_pending <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 8'h00;
    end else begin
      // Q is valid one edge after the macro saw the read; capture wins over drain.
      if (rd_pend) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= SRAM_Q;
      end else if (rsp_valid && bus.RSP_READY) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        S_INIT: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'hFF) state <= S_RUN;
        end
        default: begin
          rd_pend <= acc & ~bus.REQ_WE;
          // Let an outstanding read land before the fill overwrites the array.
          if (clear_pending && !rd_pend) begin
            state         <= S_INIT;
            cnt           <= 8'h00;
            clear_pending <= 1'b0;
          end else if (CLEAR) begin
            clear_pending <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram256x8_req_ctrl.sv
// Bench for sram256x8_req_ctrl: behavioural SRAM macro, a word-level memory
// model that predicts every cycle's handshake, pins and response, directed
// steps from the test plan followed by a randomized phase.
module tb_sram256x8_req_ctrl;
  localparam logic [7:0] INIT_V = 8'h00;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CLEAR;
  logic       INIT_DONE;
  logic       SRAM_CEN, SRAM_GWEN;
  logic [7:0] SRAM_WEN, SRAM_A, SRAM_D, SRAM_Q;

  sram256x8_req_ctrl_if bus ();

  sram256x8_req_ctrl #(.INIT_ON_RESET(1'b1), .INIT_VALUE(INIT_V)) dut (
    .CLK(CLK), .RST(RST), .CLEAR(CLEAR), .INIT_DONE(INIT_DONE), .bus(bus),
    .SRAM_CEN(SRAM_CEN), .SRAM_GWEN(SRAM_GWEN), .SRAM_WEN(SRAM_WEN),
    .SRAM_A(SRAM_A), .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural macro: bit-masked write, registered read port.
  logic [7:0] sram [256];
  always @(posedge CLK) begin
    if (!SRAM_CEN) begin
      if (!SRAM_GWEN) begin
        for (int b = 0; b < 8; b++)
          if (!SRAM_WEN[b]) sram[SRAM_A][b] <= SRAM_D[b];
      end else begin
        SRAM_Q <= sram[SRAM_A];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] ref_mem [256];
  bit         m_known = 0;
  bit         m_init, m_rdw, m_rv, m_clr;
  int         m_fill;
  logic [7:0] m_rdd, m_rdata;

  logic       last_cen, last_ready;
  logic [7:0] last_wen, last_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance the model at posedge.
  task automatic cyc(input bit rst, input bit clr, input bit v, input bit we,
                     input logic [7:0] addr, input logic [7:0] wd,
                     input logic [7:0] wm, input bit rr);
    bit ready_e, acc, prev_rdw;
    logic cen_e, gwen_e;
    logic [7:0] wen_e, a_e, d_e;
    @(negedge CLK);
    RST = rst; CLEAR = clr;
    bus.REQ_VALID = v; bus.REQ_WE = we; bus.REQ_ADDR = addr;
    bus.REQ_WDATA = wd; bus.REQ_WMASK = wm; bus.RSP_READY = rr;
    #1;
    ready_e = !rst && !m_init && !m_rdw && !m_clr && (!m_rv || rr);
    acc     = v && ready_e;
    cen_e = 1'b1; gwen_e = 1'b1; wen_e = 8'hFF; a_e = 8'h00; d_e = 8'h00;
    if (!rst) begin
      if (m_init) begin
        cen_e = 1'b0; gwen_e = 1'b0; wen_e = 8'h00; a_e = m_fill[7:0]; d_e = INIT_V;
      end else if (acc && we && wm != 8'h00) begin
        cen_e = 1'b0; gwen_e = 1'b0; wen_e = ~wm; a_e = addr; d_e = wd;
      end else if (acc && !we) begin
        cen_e = 1'b0; a_e = addr;
      end
    end
    chk("req_ready", REQ_READY_w(), ready_e);
    chk("sram_cen", SRAM_CEN, cen_e);
    chk("sram_gwen", SRAM_GWEN, gwen_e);
    chk("sram_wen", SRAM_WEN, wen_e);
    chk("sram_a", SRAM_A, a_e);
    chk("sram_d", SRAM_D, d_e);
    if (m_known) begin
      chk("init_done", INIT_DONE, !m_init);
      chk("rsp_valid", bus.RSP_VALID, m_rv);
      chk("rsp_rdata", bus.RSP_RDATA, m_rdata);
    end
    last_cen = SRAM_CEN; last_wen = SRAM_WEN; last_a = SRAM_A; last_ready = bus.REQ_READY;
    @(posedge CLK);
    if (rst) begin
      m_known = 1; m_init = 1; m_fill = 0; m_rdw = 0; m_rv = 0; m_rdata = 8'h00; m_clr = 0;
    end else begin
      prev_rdw = m_rdw;
      if (m_rdw) begin
        m_rv = 1; m_rdata = m_rdd; m_rdw = 0;
      end else if (m_rv && rr) begin
        m_rv = 0;
      end
      if (m_init) begin
        ref_mem[m_fill] = INIT_V;
        if (m_fill == 255) begin m_init = 0; m_fill = 0; end
        else m_fill++;
      end else begin
        if (acc) begin
          if (we) ref_mem[addr] = (ref_mem[addr] & ~wm) | (wd & wm);
          else begin m_rdw = 1; m_rdd = ref_mem[addr]; end
        end
        if (m_clr && !prev_rdw) begin m_init = 1; m_fill = 0; m_clr = 0; end
        else if (clr) m_clr = 1;
      end
    end
    #1;
  endtask

  function automatic logic REQ_READY_w();
    return bus.REQ_READY;
  endfunction

  task automatic idle(input bit rr);
    cyc(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, rr);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] m);
    cyc(0, 0, 1, 1, a, d, m, 1);
  endtask

  task automatic rd(input logic [7:0] a, input bit rr);
    cyc(0, 0, 1, 0, a, 8'h00, 8'h00, rr);
  endtask

  // Run idle cycles until the fill finishes; returns the number of CEN-low cycles.
  task automatic wait_fill(input bit rr, output int n, output logic [7:0] first_a);
    n = 0; first_a = 8'hEE;
    for (int i = 0; i < 300 && !INIT_DONE; i++) begin
      idle(rr);
      if (!last_cen) begin
        if (n == 0) first_a = last_a;
        n++;
      end
    end
  endtask

  initial begin
    int n;
    logic [7:0] fa;
    logic [7:0] wen1, wen2;
    logic [7:0] wm;
    RST = 1; CLEAR = 0;
    bus.REQ_VALID = 0; bus.REQ_WE = 0; bus.REQ_ADDR = 0;
    bus.REQ_WDATA = 0; bus.REQ_WMASK = 0; bus.RSP_READY = 0;

    // Reset, then the automatic fill
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    chk("rst_rsp_valid", bus.RSP_VALID, 1'b0);
    chk("rst_rsp_rdata", bus.RSP_RDATA, 8'h00);
    chk("rst_init_done", INIT_DONE, 1'b0);
    wait_fill(1, n, fa);
    chk("fill_cycles", n, 256);
    chk("fill_first_a", fa, 8'h00);
    chk("fill_done", INIT_DONE, 1'b1);
    chk("ready_after_fill", bus.REQ_READY, 1'b1);

    // Read of a filled word; two edges after accept the response is valid
    rd(8'h7F, 0);
    idle(0);
    chk("rd7f_valid", bus.RSP_VALID, 1'b1);
    chk("rd7f_data", bus.RSP_RDATA, 8'h00);
    idle(1);

    // Full write, then low-nibble clear, then readback
    wr(8'h12, 8'hA5, 8'hFF); wen1 = last_wen;
    wr(8'h12, 8'h00, 8'h0F); wen2 = last_wen;
    chk("wen_full", wen1, 8'h00);
    chk("wen_nibble", wen2, 8'hF0);
    rd(8'h12, 1);
    idle(0);
    chk("mask_rdata", bus.RSP_RDATA, 8'hA0);
    idle(1);

    // Zero-mask write: accepted, no macro access, contents unchanged
    wr(8'h12, 8'hFF, 8'h00);
    chk("zmask_cen", last_cen, 1'b1);
    chk("zmask_ready", last_ready, 1'b1);
    rd(8'h12, 1);
    idle(0);
    chk("zmask_rdata", bus.RSP_RDATA, 8'hA0);
    idle(1);

    // Backpressure: response held for 5 cycles, then back-to-back accept on drain
    rd(8'h12, 1);
    idle(0);
    for (int i = 0; i < 5; i++) begin
      rd(8'h34, 0);
      chk("bp_ready", last_ready, 1'b0);
      chk("bp_rdata", bus.RSP_RDATA, 8'hA0);
    end
    rd(8'h34, 1);
    chk("bp_accept", last_ready, 1'b1);
    idle(0);
    chk("bp2_rdata", bus.RSP_RDATA, 8'h00);
    idle(1);

    // CLEAR while a read is pending: old data still delivered, then refill
    rd(8'h12, 0);
    cyc(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) idle(0);
    chk("clr_in_init", INIT_DONE, 1'b0);
    chk("clr_rsp_valid", bus.RSP_VALID, 1'b1);
    chk("clr_rsp_rdata", bus.RSP_RDATA, 8'hA0);
    wait_fill(1, n, fa);
    chk("clr_done", INIT_DONE, 1'b1);
    rd(8'h12, 1);
    idle(0);
    chk("clr_readback", bus.RSP_RDATA, 8'h00);
    idle(1);

    // Reset at fill cycle 100: fill restarts from 0 and runs a full 256 cycles
    wr(8'h12, 8'h3C, 8'hFF);
    cyc(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    idle(1);
    for (int i = 0; i < 100; i++) idle(1);
    chk("mid_fill", INIT_DONE, 1'b0);
    cyc(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    cyc(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    wait_fill(1, n, fa);
    chk("rst_fill_cycles", n, 256);
    chk("rst_fill_first_a", fa, 8'h00);

    // Reset during a pending read drops it
    rd(8'h12, 1);
    cyc(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    chk("rst_drop_valid", bus.RSP_VALID, 1'b0);
    wait_fill(1, n, fa);
    chk("rst2_fill_cycles", n, 256);

    // Randomized traffic on a small address window to exercise read-after-write
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(2, 0))
        0: wm = 8'h00;
        1: wm = 8'hFF;
        default: wm = 8'($urandom);
      endcase
      cyc(0, ($urandom_range(299, 0) == 0), ($urandom_range(3, 0) != 0),
          1'($urandom), 8'($urandom_range(15, 0)), 8'($urandom), wm,
          ($urandom_range(3, 0) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram256x8_req_ctrl.md
Name: sram256x8_req_ctrl

Overview:
- Request/response front end that sits directly upstream of the 256x8 bit-maskable single-port SRAM macro and drives its CEN/GWEN/WEN/A/D pins.
- Converts a valid/ready request stream into macro cycles and captures Q into a held response register with backpressure.
- Provides a hardware initialisation sequencer that fills the whole array with a constant, after reset or on demand.

Parameters:
- INIT_ON_RESET, 1, 1 = run the fill sequence automatically after reset; 0 = go straight to RUN.
- INIT_VALUE, 8'h00, data written to every word during the fill sequence.

Ports:
- CLK  in  1  clock, shared with the SRAM macro.
- RST  in  1  synchronous, active-high reset.
- CLEAR  in  1  single-cycle pulse that requests a fill sequence.
- INIT_DONE  out  1  high while in RUN.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller accepts the request this cycle.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  8  word address.
- REQ_WDATA  in  8  write data.
- REQ_WMASK  in  8  per-bit write enable, active high.
- RSP_VALID  out  1  read data available.
- RSP_READY  in  1  consumer takes the response.
- RSP_RDATA  out  8  read data.
- SRAM_CEN  out  1  to macro CEN, active low.
- SRAM_GWEN  out  1  to macro GWEN, active low.
- SRAM_WEN  out  8  to macro WEN, active low per bit.
- SRAM_A  out  8  to macro A.
- SRAM_D  out  8  to macro D.
- SRAM_Q  in  8  from macro Q.

Behaviour:
- States: INIT, RUN. Reset enters INIT if INIT_ON_RESET=1, otherwise RUN.
- Reset values: REQ_READY=0, RSP_VALID=0, RSP_RDATA=0, INIT_DONE=0 (1 if INIT_ON_RESET=0), internal address counter=0, rd_pend=0.
- While RST is high, macro pins are forced idle: CEN=1, GWEN=1, WEN=8'hFF, A=0, D=0.
- Macro pins are combinational from state and the accepted request. The macro samples them at the next CLK edge.
- Idle pin values in any cycle with no access: CEN=1, GWEN=1, WEN=8'hFF. A and D are don't-care; they are driven 0.
- INIT:
  - Each cycle drives CEN=0, GWEN=0, WEN=8'h00, A=counter, D=INIT_VALUE.
  - Counter increments every cycle. When counter=255 is written, it wraps to 0 and the state moves to RUN.
  - Duration is exactly 256 cycles. REQ_READY=0 and INIT_DONE=0 throughout.
- RUN:
  - REQ_READY = ~rd_pend & (~RSP_VALID | RSP_READY) & ~clear_pending. A request is accepted in a cycle where REQ_VALID & REQ_READY.
- Accepted write:
  - Drives CEN=0, GWEN=0, WEN=~REQ_WMASK, A=REQ_ADDR, D=REQ_WDATA.
  - If REQ_WMASK=8'h00, no macro access occurs (CEN stays 1), but the request is still accepted.
  - Writes produce no response.
- Accepted read:
  - Drives CEN=0, GWEN=1, WEN=8'hFF, A=REQ_ADDR.
  - Sets rd_pend at edge E. At edge E+1, RSP_RDATA <= SRAM_Q, RSP_VALID <= 1, rd_pend <= 0.
  - Latency: RSP_VALID is high from the cycle after E+1.
  - Peak read throughput is 1 per 2 cycles.
- Response:
  - RSP_VALID and RSP_RDATA hold stable until RSP_VALID & RSP_READY.
  - RSP_VALID clears on that edge unless a new capture occurs on the same edge.
  - A same-edge capture reloads the register and keeps RSP_VALID=1.
- Read-after-write to the same address returns the newly written data (macro is sequential, and requests are in order).
- CLEAR:
  - A pulse sets clear_pending, which blocks new requests.
  - When clear_pending=1 and rd_pend=0, the next edge enters INIT with counter=0 and clears clear_pending.
  - An outstanding response is still delivered; RSP_VALID and RSP_RDATA are untouched by INIT.
  - CLEAR during INIT is ignored.
- RST mid-operation: pending read is dropped; RSP_VALID=0 next edge; fill restarts from address 0.
- No X propagation: RSP_RDATA updates only on capture.

Test Plan:
- Reset with INIT_ON_RESET=1 → SRAM_CEN=0 for exactly 256 consecutive cycles with A sequencing 0..255 and D=8'h00; then INIT_DONE=1 and REQ_READY=1. Read of addr 8'h7F → RSP_RDATA=8'h00.
- Write A=8'h12 D=8'hA5 mask=8'hFF, then write D=8'h00 mask=8'h0F, then read 8'h12 → SRAM_WEN=8'h00 then 8'hF0; response 8'hA0 two edges after the read is accepted.
- Write with mask=8'h00 → accepted, SRAM_CEN stays 1, memory unchanged on readback.
- Read with RSP_READY held low for 5 cycles → RSP_VALID and RSP_RDATA stable; REQ_READY=0 until the handshake. Then a back-to-back read is accepted the same cycle RSP_READY=1.
- CLEAR pulse while a read is pending → read response delivered with the old data; then 256-cycle fill; readback of previously written addr 8'h12 → 8'h00.
- RST asserted at fill cycle 100 and during a pending read → RSP_VALID=0, macro pins idle during reset; fill restarts at A=0 and completes after 256 cycles.
